// File: rtl/common_pkg.sv
// Shared decode types plus the combinational control and immediate generators
// used by the decode stage.
package common_pkg;

  typedef logic [31:0] instruction_t;

  typedef struct packed {
    logic [3:0] alu_op;       // {funct7[5], funct3} for ALU ops, 0 otherwise
    logic       alu_src_imm;  // second ALU operand is the immediate
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       lui;
    logic       auipc;
    logic       illegal;
  } control_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Only RV32E (16) and RV32I (32) register files are supported.
  function automatic logic num_regs_legal(input int n);
    return (n == 16) || (n == 32);
  endfunction

  // Control block: opcode/funct fields to control word.
  function automatic control_t decode_control(input instruction_t ins);
    control_t c;
    c = '0;
    case (ins[6:0])
      OPC_LOAD:   begin c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src_imm = 1'b1; end
      OPC_STORE:  begin c.mem_write = 1'b1; c.alu_src_imm = 1'b1; end
      OPC_OP:     begin c.reg_write = 1'b1; c.alu_op = {ins[30], ins[14:12]}; end
      OPC_OP_IMM: begin
        c.reg_write   = 1'b1;
        c.alu_src_imm = 1'b1;
        // Only shifts-right use funct7[5] (srai vs srli); elsewhere those bits are immediate.
        c.alu_op      = {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12]};
      end
      OPC_BRANCH: c.branch = 1'b1;
      OPC_JAL:    begin c.jump = 1'b1; c.reg_write = 1'b1; end
      OPC_JALR:   begin c.jump = 1'b1; c.reg_write = 1'b1; c.alu_src_imm = 1'b1; end
      OPC_LUI:    begin c.lui = 1'b1; c.reg_write = 1'b1; end
      OPC_AUIPC:  begin c.auipc = 1'b1; c.reg_write = 1'b1; end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Immediate generator: sign-extended 32-bit immediate per instruction format.
  function automatic logic [31:0] gen_imm(input instruction_t ins);
    logic [31:0] imm;
    case (ins[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {ins[31:12], 12'b0};
      OPC_JAL:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:    imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two write-first read ports, one write port.
// x0 and ids beyond NUM_REGS read as zero and ignore writes.
module decode_regfile
  import common_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [4:0]      wr_id_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [4:0]      rd1_id_i,
  output logic [XLEN-1:0] rd1_data_o,
  input  logic [4:0]      rd2_id_i,
  output logic [XLEN-1:0] rd2_data_o
);

  localparam int AW = $clog2(NUM_REGS);

  if (!num_regs_legal(NUM_REGS)) begin : g_bad_num_regs
    $error("decode_regfile: NUM_REGS must be 16 or 32");
  end

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_ok;

  function automatic logic id_live(input logic [4:0] id);
    return (id != 5'd0) && (32'(id) < NUM_REGS);
  endfunction

  // Write-first: a same-cycle write to the addressed register wins over storage.
  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] id);
    if (!id_live(id)) return '0;
    if (wr_ok && (wr_id_i == id)) return wr_data_i;
    return regs_q[id[AW-1:0]];
  endfunction

  assign wr_ok      = wr_en_i && id_live(wr_id_i);
  assign rd1_data_o = rd_port(rd1_id_i);
  assign rd2_data_o = rd_port(rd2_id_i);

  // Storage update; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_id_i[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode pipeline stage: decodes one instruction per cycle into a registered
// bundle with valid/ready handshake, load-use bubble insertion and flush.
module decode_pipe_stage
  import common_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  instruction_t    instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_id,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_immediate_data,
  output logic [XLEN-1:0] out_read1_data,
  output logic [XLEN-1:0] out_read2_data,
  output control_t        out_control,
  output logic [4:0]      out_rs1_id,
  output logic [4:0]      out_rs2_id,
  output logic [4:0]      out_rd_id,
  output logic [31:0]     stall_count
);

  logic [4:0]      rs1, rs2, rd;
  control_t        ctrl_dec;
  logic [XLEN-1:0] imm_dec;
  logic            hazard, accept, hold;
  logic [4:0]      rd1_addr, rd2_addr;
  logic [XLEN-1:0] rd1_data, rd2_data;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, r1_q, r1_d, r2_q, r2_d;
  control_t        ctrl_q, ctrl_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0]     stall_q, stall_d;

  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign rd       = instruction[11:7];
  assign ctrl_dec = decode_control(instruction);
  assign imm_dec  = XLEN'(signed'(gen_imm(instruction)));

  // Load-use: the held bundle is a load whose destination the incoming instruction reads.
  assign hazard = in_valid && valid_q && ctrl_q.mem_read && (rd_q != 5'd0) &&
                  ((rd_q == rs1) || (rd_q == rs2));
  assign in_ready = flush || ((!valid_q || out_ready) && !hazard);
  assign accept   = in_valid && in_ready && !flush;
  assign hold     = valid_q && !out_ready;

  // While holding, the read ports track the held ids so write-back refreshes the operands.
  assign rd1_addr = hold ? rs1_q : rs1;
  assign rd2_addr = hold ? rs2_q : rs2;

  decode_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wb_en),
    .wr_id_i    (wb_id),
    .wr_data_i  (wb_data),
    .rd1_id_i   (rd1_addr),
    .rd1_data_o (rd1_data),
    .rd2_id_i   (rd2_addr),
    .rd2_data_o (rd2_data)
  );

  // Next-state selection: flush beats accept, accept beats hold, otherwise drain/bubble.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    stall_d = stall_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = pc;
      imm_d   = imm_dec;
      r1_d    = rd1_data;
      r2_d    = rd2_data;
      ctrl_d  = ctrl_dec;
      rs1_d   = rs1;
      rs2_d   = rs2;
      rd_d    = rd;
    end else if (hold) begin
      r1_d = rd1_data;
      r2_d = rd2_data;
    end else begin
      valid_d = 1'b0;
      // Reaching here with a hazard means out_ready=1: this cycle becomes a bubble.
      if (hazard && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end
  end

  // Bundle and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid          = valid_q;
  assign out_pc             = pc_q;
  assign out_immediate_data = imm_q;
  assign out_read1_data     = r1_q;
  assign out_read2_data     = r2_q;
  assign out_control        = ctrl_q;
  assign out_rs1_id         = rs1_q;
  assign out_rs2_id         = rs2_q;
  assign out_rd_id          = rd_q;
  assign stall_count        = stall_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: a 32-register instance (a_*) and a 16-register
// instance (b_*) share all inputs; expected bundles are queued as driven.
module tb_decode_pipe_stage;
  import common_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, wb_en, flush, out_ready;
  instruction_t instruction;
  logic [31:0] pc, wb_data;
  logic [4:0]  wb_id;

  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_pc, a_imm, a_r1, a_r2, a_stall, b_pc, b_imm, b_r1, b_r2, b_stall;
  control_t a_ctrl, b_ctrl;
  logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;

  decode_pipe_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instruction(instruction), .pc(pc), .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_immediate_data(a_imm), .out_read1_data(a_r1), .out_read2_data(a_r2),
    .out_control(a_ctrl), .out_rs1_id(a_rs1), .out_rs2_id(a_rs2), .out_rd_id(a_rd),
    .stall_count(a_stall)
  );

  decode_pipe_stage #(.XLEN(32), .NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .instruction(instruction), .pc(pc), .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_immediate_data(b_imm), .out_read1_data(b_r1), .out_read2_data(b_r2),
    .out_control(b_ctrl), .out_rs1_id(b_rs1), .out_rs2_id(b_rs2), .out_rd_id(b_rd),
    .stall_count(b_stall)
  );

  typedef struct packed {
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  rs1, rs2, rd;
    logic        mem_read, reg_write;
  } bundle_t;

  bundle_t exp_q[$];
  bundle_t cur;
  int total = 0;
  int bad   = 0;

  localparam logic [6:0] T_LOAD = 7'b0000011;
  localparam logic [6:0] T_OPI  = 7'b0010011;

  function automatic instruction_t enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic instruction_t enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic bundle_t mk(input logic [31:0] p, input logic [31:0] imm, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] d, input logic mr, input logic rw);
    bundle_t b;
    b.pc = p; b.imm = imm; b.r1 = r1; b.r2 = r2; b.rs1 = s1; b.rs2 = s2; b.rd = d;
    b.mem_read = mr; b.reg_write = rw;
    return b;
  endfunction

  function automatic bundle_t obs_a();
    return mk(a_pc, a_imm, a_r1, a_r2, a_rs1, a_rs2, a_rd, a_ctrl.mem_read, a_ctrl.reg_write);
  endfunction

  function automatic bundle_t obs_b();
    return mk(b_pc, b_imm, b_r1, b_r2, b_rs1, b_rs2, b_rd, b_ctrl.mem_read, b_ctrl.reg_write);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instruction = '0; pc = '0;
    wb_en = 1'b0; wb_id = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", a_out_valid); end
    total++; if (a_stall !== 32'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
    total++; if (a_ctrl !== control_t'('0)) begin bad++; $display("FAIL reset_ctrl: got %h want 0", a_ctrl); end
    total++; if (obs_a() !== bundle_t'('0)) begin bad++; $display("FAIL reset_bundle: got %h want 0", obs_a()); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
  endtask

  task automatic test_wb_read();
    @(negedge clk);
    wb_en = 1'b1; wb_id = 5'd5; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b1; instruction = enc_r(5'd1, 5'd5, 5'd0); pc = 32'h100; out_ready = 1'b1;
    exp_q.push_back(mk(32'h100, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd0, 5'd1, 1'b0, 1'b1));
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL wb_read_valid: got %0b want 1", a_out_valid); end
    cur = exp_q.pop_front();
    total++; if (obs_a() !== cur) begin bad++; $display("FAIL wb_read_bundle: got %h want %h", obs_a(), cur); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wb_en = 1'b1; wb_id = 5'd9; wb_data = 32'hA5A5_A5A5;
    in_valid = 1'b1; instruction = enc_r(5'd2, 5'd0, 5'd9); pc = 32'h104;
    exp_q.push_back(mk(32'h104, 32'h0, 32'h0, 32'hA5A5_A5A5, 5'd0, 5'd9, 5'd2, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL bypass_bundle: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    @(negedge clk);
    wb_en = 1'b0; instruction = enc_r(5'd2, 5'd9, 5'd9); pc = 32'h108;
    exp_q.push_back(mk(32'h108, 32'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd2, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL stored_bundle: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hazard();
    @(negedge clk);
    in_valid = 1'b1; instruction = enc_i(T_LOAD, 3'b010, 5'd3, 5'd2, 12'h000); pc = 32'h200; out_ready = 1'b1;
    exp_q.push_back(mk(32'h200, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL lw_bundle: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    @(negedge clk);
    instruction = enc_r(5'd4, 5'd3, 5'd3); pc = 32'h204;
    #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL hazard_in_ready: got %0b want 0", a_in_ready); end
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid: got %0b want 0", a_out_valid); end
    total++; if (a_stall !== 32'd1) begin bad++; $display("FAIL bubble_stall: got %0d want 1", a_stall); end
    @(negedge clk); #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL after_bubble_ready: got %0b want 1", a_in_ready); end
    exp_q.push_back(mk(32'h204, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL add_after_bubble: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    total++; if (a_stall !== 32'd1) begin bad++; $display("FAIL stall_once: got %0d want 1", a_stall); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    control_t ctrl_e;
    ctrl_e = '0; ctrl_e.alu_src_imm = 1'b1; ctrl_e.reg_write = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; instruction = enc_i(T_OPI, 3'b000, 5'd8, 5'd7, 12'hFFC); pc = 32'h300; out_ready = 1'b0;
    exp_q.push_back(mk(32'h300, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd7, 5'd28, 5'd8, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL hold_first: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instruction = enc_r(5'd9, 5'd1, 5'd1); pc = 32'h304; in_valid = 1'b1;
      if (k == 0) begin
        wb_en = 1'b1; wb_id = 5'd7; wb_data = 32'h1234_5678; cur.r1 = 32'h1234_5678;
      end else begin
        wb_en = 1'b0;
      end
      #1;
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d]: got %0b want 0", k, a_in_ready); end
      @(posedge clk); #1;
      total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL hold_bundle[%0d]: got v=%0b %h want %h", k, a_out_valid, obs_a(), cur); end
      total++; if (a_ctrl !== ctrl_e) begin bad++; $display("FAIL hold_ctrl[%0d]: got %h want %h", k, a_ctrl, ctrl_e); end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0; wb_en = 1'b0;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; instruction = enc_i(T_LOAD, 3'b010, 5'd12, 5'd0, 12'h000); pc = 32'h400; out_ready = 1'b0;
    exp_q.push_back(mk(32'h400, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL flush_held: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    @(negedge clk);
    flush = 1'b1; instruction = enc_r(5'd11, 5'd12, 5'd12); pc = 32'h404; in_valid = 1'b1; out_ready = 1'b1;
    wb_en = 1'b1; wb_id = 5'd10; wb_data = 32'h77;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %0b want 1", a_in_ready); end
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", a_out_valid); end
    total++; if (a_stall !== 32'd1) begin bad++; $display("FAIL flush_stall: got %0d want 1", a_stall); end
    @(negedge clk);
    flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_nothing_issued: got %0b want 0", a_out_valid); end
    @(negedge clk);
    in_valid = 1'b1; instruction = enc_r(5'd11, 5'd10, 5'd0); pc = 32'h408;
    exp_q.push_back(mk(32'h408, 32'h0, 32'h77, 32'h0, 5'd10, 5'd0, 5'd11, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL flush_wb_kept: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] imms [4];
    imms[0] = 12'h7FF; imms[1] = 12'h800; imms[2] = 12'hFFC; imms[3] = 12'h001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; instruction = enc_i(T_OPI, 3'b000, 5'(13 + i), 5'd5, imms[i]); pc = 32'h500 + 32'(4 * i);
      exp_q.push_back(mk(pc, {{20{imms[i][11]}}, imms[i]}, 32'hDEAD_BEEF, 32'h0, 5'd5, imms[i][4:0],
                         5'(13 + i), 1'b0, 1'b1));
      #1;
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, a_in_ready); end
      @(posedge clk); #1;
      cur = exp_q.pop_front();
      total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL b2b_bundle[%0d]: got v=%0b %h want %h", i, a_out_valid, obs_a(), cur); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_regs16();
    @(negedge clk);
    wb_en = 1'b1; wb_id = 5'd20; wb_data = 32'h1;
    @(negedge clk);
    wb_id = 5'd0; wb_data = 32'hFF;
    @(negedge clk);
    wb_id = 5'd15; wb_data = 32'hCAFE;
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1; instruction = enc_r(5'd1, 5'd20, 5'd15); pc = 32'h600;
    exp_q.push_back(mk(32'h600, 32'h0, 32'h0, 32'hCAFE, 5'd20, 5'd15, 5'd1, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (b_out_valid !== 1'b1 || obs_b() !== cur) begin bad++; $display("FAIL rv32e_x20: got v=%0b %h want %h", b_out_valid, obs_b(), cur); end
    total++; if (a_r1 !== 32'h1) begin bad++; $display("FAIL rv32i_x20: got %h want 00000001", a_r1); end
    @(negedge clk);
    instruction = enc_r(5'd1, 5'd0, 5'd0); pc = 32'h604;
    exp_q.push_back(mk(32'h604, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (b_out_valid !== 1'b1 || obs_b() !== cur) begin bad++; $display("FAIL rv32e_x0: got v=%0b %h want %h", b_out_valid, obs_b(), cur); end
    total++; if (a_r1 !== 32'h0) begin bad++; $display("FAIL rv32i_x0: got %h want 00000000", a_r1); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    in_valid = 1'b1; instruction = enc_r(5'd1, 5'd5, 5'd5); pc = 32'h700; out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL midflight_valid: got %0b want 1", a_out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midflight_drop: got %0b want 0", a_out_valid); end
    total++; if (a_stall !== 32'd0) begin bad++; $display("FAIL midflight_stall: got %0d want 0", a_stall); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %0b want 1", a_in_ready); end
    @(negedge clk);
    in_valid = 1'b1; instruction = enc_r(5'd1, 5'd5, 5'd0); pc = 32'h704;
    exp_q.push_back(mk(32'h704, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd1, 1'b0, 1'b1));
    @(posedge clk); #1;
    cur = exp_q.pop_front();
    total++; if (a_out_valid !== 1'b1 || obs_a() !== cur) begin bad++; $display("FAIL regfile_cleared: got v=%0b %h want %h", a_out_valid, obs_a(), cur); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_wb_read();
    test_bypass();
    test_hazard();
    test_hold();
    test_flush();
    test_back_to_back();
    test_regs16();
    test_reset_midflight();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameter XLEN, 32, data/PC width in bits.
REQ-002 Parameter NUM_REGS, 32, architectural register count; legal values are 16 (RV32E) or 32.
REQ-003 clk  in  1  single clock; all state rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream (fetch) holds a valid instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 instruction  in  instruction_t  fetched instruction word.
REQ-008 pc  in  XLEN  PC of instruction.
REQ-009 wb_en  in  1  write-back enable.
REQ-010 wb_id  in  5  write-back destination register.
REQ-011 wb_data  in  XLEN  write-back data.
REQ-012 flush  in  1  discard the held and incoming instruction.
REQ-013 out_valid  out  1  decoded bundle valid.
REQ-014 out_ready  in  1  execute stage accepts the bundle.
REQ-015 out_pc, out_immediate_data, out_read1_data, out_read2_data  out  XLEN each  registered decode results.
REQ-016 out_control  out  control_t  registered control word.
REQ-017 out_rs1_id, out_rs2_id, out_rd_id  out  5 each  registered register ids.
REQ-018 stall_count  out  32  saturating count of load-use bubble cycles.

Function
REQ-019 Accept = in_valid && in_ready; an accepted instruction SHALL appear on the outputs with out_valid=1 on the next edge (latency 1).
REQ-020 in_ready SHALL be (!out_valid || out_ready) && !hazard, or 1 while flush=1.
REQ-021 hazard SHALL be in_valid && out_valid && out_control.mem_read && out_rd_id!=0 && (out_rd_id==rs1 || out_rd_id==rs2) of the incoming instruction.
REQ-022 Hazard with out_ready=1: out_valid SHALL drop to 0 for exactly one cycle (bubble), then the instruction is accepted; stall_count SHALL increment once per bubble cycle, saturating at 0xFFFFFFFF.
REQ-023 out_valid=1 && out_ready=0: all outputs SHALL hold, except that a wb write to out_rs1_id/out_rs2_id (id!=0) SHALL refresh out_read1_data/out_read2_data.
REQ-024 out_valid=1 && out_ready=1 with no accept: out_valid SHALL go 0 next cycle.
REQ-025 Register file reads SHALL be write-first: same-cycle wb_en with wb_id==rs (rs!=0) returns wb_data.
REQ-026 Register 0 SHALL read 0; writes to 0 SHALL be ignored.
REQ-027 Ids >= NUM_REGS SHALL read 0, and writes to them SHALL be ignored.
REQ-028 flush SHALL take priority over accept, hazard and hold: out_valid SHALL become 0 next cycle, the incoming instruction SHALL be discarded, and register-file writes still complete.
REQ-029 Immediate and control SHALL be produced combinationally by the existing control and imm_gen blocks and then registered.

Reset
REQ-030 On rst: out_valid=0, out_control='0, all out_* data/id registers=0, stall_count=0, and all register-file entries=0.
REQ-031 rst asserted mid-transfer SHALL drop the in-flight bundle; in_ready SHALL be 1 on the first cycle after deassertion.

Structure
REQ-032 instruction_t and control_t (including mem_read) SHALL remain in common_pkg; no new package types are needed beyond a NUM_REGS legality check.
REQ-033 The register file with write-first bypass and NUM_REGS masking SHALL be one sub-module, decode_regfile.
REQ-034 Valid/ready, hazard, flush and counter logic SHALL live in decode_pipe_stage.

Verification
REQ-035 Reset, write x5=0xDEADBEEF, then decode "add x1,x5,x0" with out_ready=1 -> out_valid next cycle, out_read1_data=0xDEADBEEF, out_read2_data=0.
REQ-036 "lw x3,0(x2)" accepted, then "add x4,x3,x3" with out_ready=1 -> one bubble cycle, in_ready=0 for one cycle, stall_count=1, and the add is issued the following cycle.
REQ-037 out_ready=0 for 3 cycles while bundle holds rs1=x7, and wb writes x7=0x12345678 -> pc, immediate and control unchanged, out_read1_data=0x12345678.
REQ-038 Same-cycle wb_en, wb_id=9, wb_data=0xA5A5A5A5 while decoding rs2=x9 -> out_read2_data=0xA5A5A5A5.
REQ-039 NUM_REGS=16: write x20=0x1, then read x20 -> 0; write x0=0xFF, then read x0 -> 0.
REQ-040 flush asserted together with in_valid=1 and a held bundle -> out_valid=0 next cycle, nothing issued, and stall_count unchanged.
